seq_hit_monitor: RTL
====================

Name: seq_hit_monitor

Overview:
- Downstream stage of the 4-bit sequence detector. Consumes its one-cycle found pulse and counts detections.
- Raises a level interrupt after IRQ_THRESH detections, held until a 4-phase acknowledge handshake completes.
- Exposes a saturating hit count, a sticky overflow flag and a per-hit strobe for the status/CPU side.

Parameters:
CNT_W, 8, width of the total hit counter. Legal range 2..16.
IRQ_THRESH, 1, number of hits since the last acknowledge that triggers irq_o. Legal range 1..2^CNT_W-1; 0 is illegal and is caught by an elaboration-time check.

Ports:
clk_i  input  1  clock, all logic on the rising edge
rst_i  input  1  reset, synchronous, active-high; one clock, and reset is synchronous and active-high
found_i  input  1  detection flag from the sequence detector
ack_i  input  1  interrupt acknowledge, 4-phase level handshake
clr_i  input  1  synchronous clear of hit_count_o and overflow_o
hit_pulse_o  output  1  one-cycle strobe per counted hit
hit_count_o  output  CNT_W  total hits, saturating
overflow_o  output  1  sticky flag: a hit arrived while the count was saturated
irq_o  output  1  interrupt request level

Behaviour:
- Reset (rst_i=1 at an edge) sets all of the following to 0: hit_count_o, overflow_o, hit_pulse_o, irq_o, pend_cnt, found_q. State goes to S_IDLE. Reset overrides every other input.
- Hit definition: hit = found_i & ~found_q, where found_q is found_i registered. A level held high for several cycles counts once. found_i high on the first cycle after reset counts as a hit.
- Latency: with found_i rising in cycle N, hit_pulse_o, hit_count_o and, if the threshold is reached, irq_o all update at the edge ending cycle N. They are visible in cycle N+1.
- hit_count_o:
  - +1 per hit.
  - Saturates at 2^CNT_W-1. A hit at saturation holds the count and sets overflow_o.
- clr_i:
  - Zeroes hit_count_o and overflow_o.
  - Does not affect the FSM or pend_cnt.
  - clr_i and a hit in the same cycle give hit_count_o=1 and overflow_o=0.
- pend_cnt counts hits since the last accepted ack:
  - Width clog2(IRQ_THRESH+1); saturates at IRQ_THRESH.
  - Cleared on the IRQ->ACKW transition.
  - A hit in that same cycle leaves pend_cnt=1.
- FSM (registered; irq_o = state==S_IRQ, decoded from a registered state):
  - S_IDLE: go to S_IRQ when pend_cnt_next >= IRQ_THRESH. The threshold counts the current-cycle hit.
  - S_IRQ: go to S_ACKW when ack_i=1, so irq_o falls one cycle after ack_i is sampled high. Hits keep counting.
  - S_ACKW: go to S_IDLE when ack_i=0. If pend_cnt already reached the threshold while in ACKW, S_IDLE advances to S_IRQ on the next edge. No hit is lost or double-fired.
  - ack_i high in S_IDLE is ignored.
  - Unused state encodings recover to S_IDLE.
- Hits are never dropped in any state.

Decomposition:
- Shared package seq_pkg holds:
  - state localparams S_IDLE=2'd0, S_IRQ=2'd1, S_ACKW=2'd2;
  - the shared sequence constants used by the detector (SEQ_W=4).
- One natural sub-module: rise_edge_det (clk_i, rst_i, d_i, rise_o). It is a registered-delay rising-edge detector and is reusable by the detector's front end.
- Counters and FSM stay in the top module.

Test Plan:
- Reset and single hit:
  - Stimulus: rst_i=1 for 2 cycles, then a found_i pulse at cycle 5 with IRQ_THRESH=1.
  - Required: all outputs 0 during reset. At cycle 6: hit_pulse_o=1 for one cycle, hit_count_o=1, irq_o=1.
- Handshake:
  - Stimulus: raise ack_i at cycle 10, drop it at cycle 14, with a found pulse at cycle 12.
  - Required: irq_o=0 from cycle 11. State is S_ACKW until cycle 15. irq_o=1 again from cycle 16 (pend_cnt=1 reached the threshold). hit_count_o=2.
- Threshold:
  - Stimulus: IRQ_THRESH=3, three pulses 4 cycles apart.
  - Required: irq_o stays 0 after pulses 1 and 2, and rises the cycle after pulse 3.
- Held level:
  - Stimulus: found_i high for 6 consecutive cycles.
  - Required: exactly one hit_pulse_o and hit_count_o +1.
- Saturation/overflow:
  - Stimulus: CNT_W=2, five pulses.
  - Required: count sequence 1,2,3,3,3; overflow_o set on pulse 4 and stays set.
  - Follow-up: clr_i together with pulse 6 gives hit_count_o=1, overflow_o=0.
- Reset mid-operation:
  - Stimulus: rst_i asserted while in S_IRQ with ack_i=1.
  - Required: irq_o=0, count=0 on the next cycle. The state returns to S_IDLE, and the still-high ack_i is ignored.

Source files
------------

// File: rtl/seq_pkg.sv
// Constants shared by the 4-bit sequence detector and its downstream hit monitor.
package seq_pkg;

   localparam int SEQ_W = 4;

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_IRQ  = 2'd1;
   localparam logic [1:0] S_ACKW = 2'd2;

endpackage

// File: rtl/rise_edge_det.sv
// Rising-edge detector: compares the input against its one-cycle registered copy.
module rise_edge_det (
   input  logic clk_i,
   input  logic rst_i,
   input  logic d_i,
   output logic rise_o
);

   logic r_d;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_d <= 1'b0;
      end else begin
         r_d <= d_i;
      end
   end

   // Cleared delay register makes a level already high after reset count as an edge.
   assign rise_o = d_i & ~r_d;

endmodule

// File: rtl/seq_hit_monitor.sv
// Counts sequence-detector hits, flags count overflow and raises an acked level interrupt.
//   state  | meaning
//   S_IDLE | no interrupt pending, waiting for IRQ_THRESH hits
//   S_IRQ  | irq_o asserted, waiting for ack_i high
//   S_ACKW | ack accepted, waiting for ack_i low to close the handshake
module seq_hit_monitor #(
   parameter int CNT_W      = 8,
   parameter int IRQ_THRESH = 1
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             found_i,
   input  logic             ack_i,
   input  logic             clr_i,
   output logic             hit_pulse_o,
   output logic [CNT_W-1:0] hit_count_o,
   output logic             overflow_o,
   output logic             irq_o
);

   import seq_pkg::*;

   localparam int                PEND_W   = $clog2(IRQ_THRESH + 1);
   localparam logic [PEND_W-1:0] THRESH_P = PEND_W'(IRQ_THRESH);
   localparam logic [CNT_W-1:0]  CNT_MAX  = '1;

   generate
      if (IRQ_THRESH < 1 || IRQ_THRESH > (2**CNT_W) - 1) begin : g_bad_thresh
         $error("seq_hit_monitor: IRQ_THRESH out of range");
      end
      if (CNT_W < 2 || CNT_W > 16) begin : g_bad_cnt_w
         $error("seq_hit_monitor: CNT_W out of range");
      end
   endgenerate

   logic              w_hit;
   logic              w_ack_accept;
   logic [1:0]        r_state;
   logic [1:0]        w_state_next;
   logic [PEND_W-1:0] r_pend_cnt;
   logic [PEND_W-1:0] w_pend_next;
   logic [CNT_W-1:0]  r_hit_count;
   logic              r_overflow;
   logic              r_hit_pulse;

   rise_edge_det u_rise (
      .clk_i  (clk_i),
      .rst_i  (rst_i),
      .d_i    (found_i),
      .rise_o (w_hit)
   );

   assign w_ack_accept = (r_state == S_IRQ) && ack_i;

   // A hit in the ack cycle belongs to the next interrupt window.
   always_comb begin
      w_pend_next = r_pend_cnt;
      if (w_ack_accept) begin
         w_pend_next = PEND_W'(w_hit);
      end else if (w_hit && (r_pend_cnt < THRESH_P)) begin
         w_pend_next = r_pend_cnt + PEND_W'(1);
      end
   end

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         S_IDLE:  if (w_pend_next >= THRESH_P) w_state_next = S_IRQ;
         S_IRQ:   if (ack_i)                   w_state_next = S_ACKW;
         S_ACKW:  if (!ack_i)                  w_state_next = S_IDLE;
         default: w_state_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_state     <= S_IDLE;
         r_pend_cnt  <= '0;
         r_hit_pulse <= 1'b0;
         r_hit_count <= '0;
         r_overflow  <= 1'b0;
      end else begin
         r_state     <= w_state_next;
         r_pend_cnt  <= w_pend_next;
         r_hit_pulse <= w_hit;
         if (clr_i) begin
            r_hit_count <= w_hit ? CNT_W'(1) : '0;
            r_overflow  <= 1'b0;
         end else if (w_hit) begin
            if (r_hit_count == CNT_MAX) begin
               r_overflow <= 1'b1;
            end else begin
               r_hit_count <= r_hit_count + CNT_W'(1);
            end
         end
      end
   end

   assign hit_pulse_o = r_hit_pulse;
   assign hit_count_o = r_hit_count;
   assign overflow_o  = r_overflow;
   assign irq_o       = (r_state == S_IRQ);

endmodule
